score_display_formatter: RTL and testbench



---
 rtl/score_display_formatter.sv | 100 ++++++++++
 tb/tb_score_display_formatter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/score_display_formatter.sv
// Converts score, time and game state into a packed 8-digit BCD word once per frame
// using a sequential double-dabble conversion; the result is held until the next one.
module score_display_formatter #(
  parameter bit SHOW_STATE = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_in,
  input  logic [9:0]  point_total,
  input  logic [7:0]  time_left,
  input  logic [2:0]  game_state,
  output logic [31:0] val_out,
  output logic        valid_out,
  output logic        busy_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]  state;
  logic        frame_prev;
  logic        start;
  logic [9:0]  pt_sr;
  logic [9:0]  tl_sr;
  logic [2:0]  gs_q;
  logic [15:0] pt_bcd;
  logic [11:0] tl_bcd;
  logic [3:0]  cnt;
  logic [3:0]  top_digit;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble step: correct each nibble, then shift in the next binary bit.
  function automatic logic [15:0] dabble16(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] t;
    t = {adj(bcd[15:12]), adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
    return {t[14:0], bit_in};
  endfunction

  function automatic logic [11:0] dabble12(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] t;
    t = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
    return {t[10:0], bit_in};
  endfunction

  assign start     = frame_in & ~frame_prev;
  assign busy_out  = (state != IDLE);
  assign top_digit = SHOW_STATE ? {1'b0, gs_q} : 4'h0;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      frame_prev <= 1'b0;
      pt_sr      <= '0;
      tl_sr      <= '0;
      gs_q       <= '0;
      pt_bcd     <= '0;
      tl_bcd     <= '0;
      cnt        <= '0;
      val_out    <= '0;
      valid_out  <= 1'b0;
    end else begin
      frame_prev <= frame_in;
      valid_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pt_sr  <= point_total;
            tl_sr  <= {2'b00, time_left};
            gs_q   <= game_state;
            pt_bcd <= '0;
            tl_bcd <= '0;
            cnt    <= '0;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          pt_bcd <= dabble16(pt_bcd, pt_sr[9]);
          tl_bcd <= dabble12(tl_bcd, tl_sr[9]);
          pt_sr  <= {pt_sr[8:0], 1'b0};
          tl_sr  <= {tl_sr[8:0], 1'b0};
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd9) state <= DONE;
        end
        DONE: begin
          val_out   <= {top_digit, tl_bcd, pt_bcd};
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_formatter.sv
// Directed bench for score_display_formatter: vector table plus busy, hold and
// mid-conversion reset sequences, on instances with SHOW_STATE=1 and SHOW_STATE=0.
module tb_score_display_formatter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_in;
  logic [9:0]  point_total;
  logic [7:0]  time_left;
  logic [2:0]  game_state;
  logic [31:0] val1, val0;
  logic        valid1, valid0, busy1, busy0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  pt;
    logic [7:0]  tl;
    logic [2:0]  gs;
    logic [31:0] exp1;
    logic [31:0] exp0;
  } vec_t;

  vec_t vecs[6];

  always #20 clock = ~clock;

  score_display_formatter #(.SHOW_STATE(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .frame_in(frame_in),
    .point_total(point_total), .time_left(time_left), .game_state(game_state),
    .val_out(val1), .valid_out(valid1), .busy_out(busy1)
  );

  score_display_formatter #(.SHOW_STATE(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .frame_in(frame_in),
    .point_total(point_total), .time_left(time_left), .game_state(game_state),
    .val_out(val0), .valid_out(valid0), .busy_out(busy0)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Steps until valid1 rises; returns edges elapsed (20 means it never came).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (valid1) break;
    end
  endtask

  task automatic convert(input vec_t v, input string name);
    int cyc;
    point_total = v.pt;
    time_left   = v.tl;
    game_state  = v.gs;
    frame_in    = 1'b1;
    step();
    frame_in = 1'b0;
    check({name, " busy_after_start"}, {31'd0, busy1}, 32'd1);
    wait_valid(cyc);
    check({name, " latency"}, cyc, 32'd11);
    check({name, " val_out"}, val1, v.exp1);
    check({name, " val_out_nostate"}, val0, v.exp0);
    check({name, " valid_busy_at_done"}, {30'd0, valid0, busy1}, 32'd2);
    step();
    check({name, " valid_single_cycle"}, {31'd0, valid1}, 32'd0);
    check({name, " val_out_held"}, val1, v.exp1);
  endtask

  initial begin
    int cyc;
    int pulses;

    vecs[0] = '{10'd1023, 8'd255, 3'd5, 32'h5255_1023, 32'h0255_1023};
    vecs[1] = '{10'd0,    8'd0,   3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{10'd999,  8'd100, 3'd2, 32'h2100_0999, 32'h0100_0999};
    vecs[3] = '{10'd42,   8'd9,   3'd7, 32'h7009_0042, 32'h0009_0042};
    vecs[4] = '{10'd500,  8'd60,  3'd3, 32'h3060_0500, 32'h0060_0500};
    vecs[5] = '{10'd123,  8'd45,  3'd1, 32'h1045_0123, 32'h0045_0123};

    // Reset held with frame_in toggling: outputs must stay quiet.
    reset_n     = 1'b0;
    frame_in    = 1'b0;
    point_total = 10'd123;
    time_left   = 8'd45;
    game_state  = 3'd1;
    for (int i = 0; i < 5; i++) begin
      frame_in = ~frame_in;
      step();
      check("reset val_out", val1, 32'h0);
      check("reset valid_busy", {28'd0, valid1, busy1, valid0, busy0}, 32'h0);
    end

    // Release with frame_in already high: first edge starts a conversion.
    reset_n  = 1'b1;
    frame_in = 1'b1;
    step();
    frame_in = 1'b0;
    check("release busy", {31'd0, busy1}, 32'd1);
    wait_valid(cyc);
    check("release latency", cyc, 32'd11);
    check("release val_out", val1, 32'h1045_0123);
    step();

    foreach (vecs[i]) convert(vecs[i], $sformatf("vec%0d", i));

    // Second edge 4 cycles in is dropped; input changes after latch are ignored.
    point_total = 10'd999;
    time_left   = 8'd100;
    game_state  = 3'd2;
    frame_in    = 1'b1;
    step();
    frame_in = 1'b0;
    step();
    step();
    step();
    frame_in    = 1'b1;
    point_total = 10'd7;
    time_left   = 8'd3;
    step();
    frame_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid1) pulses++;
    end
    check("busy ignore pulses", pulses, 32'd1);
    check("busy hold val_out", val1, 32'h2100_0999);
    check("busy idle after", {31'd0, busy1}, 32'd0);

    // Reset at shift 5 aborts without emitting anything.
    point_total = 10'd1023;
    time_left   = 8'd255;
    game_state  = 3'd5;
    frame_in    = 1'b1;
    step();
    frame_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    #1;
    check("midreset val_out", val1, 32'h0);
    check("midreset valid_busy", {30'd0, valid1, busy1}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (valid1) pulses++;
    end
    check("midreset no valid", pulses, 32'd0);
    check("midreset val_out stays", val1, 32'h0);
    convert(vecs[5], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
